// File: rtl/divider_sequencer.sv
// Multi-cycle restoring divider with start/ready handshake and divide-by-zero reporting.
// Define DIVIDER_SIGNED_EN for two's-complement operands; the default build divides unsigned.
module divider_sequencer #(
   parameter int WORD_LENGTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WORD_LENGTH-1:0] dividend,
   input  logic [WORD_LENGTH-1:0] divisor,
   output logic                   busy,
   output logic                   ready,
   output logic [WORD_LENGTH-1:0] result,
   output logic [WORD_LENGTH-1:0] remainder,
   output logic                   div_by_zero
);

   localparam int W  = WORD_LENGTH;
   localparam int CW = $clog2(WORD_LENGTH + 1);
   localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
   localparam logic [W-1:0]  ONES_W  = {W{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_W   = CW'(WORD_LENGTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ITERATE = 2'd1,
      S_FIXUP   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   d_q, d_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           dbz_pend_q, dbz_pend_d;
   logic [W-1:0]   result_q, result_d;
   logic [W-1:0]   remainder_q, remainder_d;
   logic           dbz_q, dbz_d;
   logic           busy_q, busy_d;
   logic           ready_q, ready_d;
   logic [W:0]     a_shift_s;
   logic [W:0]     trial_s;

`ifdef DIVIDER_SIGNED_EN
   logic           neg_quot_q, neg_quot_d;
   logic           neg_rem_q, neg_rem_d;

   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      logic [W-1:0] r;
      if (v[W-1]) begin
         r = ~v + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
      logic [W-1:0] r;
      if (n) begin
         r = ~v + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction
`endif

   // Next-state, datapath iteration and output-register loads.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      q_d         = q_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      dbz_pend_d  = dbz_pend_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      busy_d      = 1'b0;
      ready_d     = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quot_d  = neg_quot_q;
      neg_rem_d   = neg_rem_q;
`endif
      a_shift_s   = {a_q, q_q[W-1]};
      trial_s     = a_shift_s - {1'b0, d_q};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d   = ZERO_W;
               cnt_d = CNT_W;
               if (divisor == ZERO_W) begin
                  // Zero divisor detours through FIXUP with busy low so ready timing stays fixed.
                  q_d        = dividend;
                  d_d        = ZERO_W;
                  dbz_pend_d = 1'b1;
                  state_d    = S_FIXUP;
               end else begin
                  dbz_pend_d = 1'b0;
                  busy_d     = 1'b1;
                  state_d    = S_ITERATE;
`ifdef DIVIDER_SIGNED_EN
                  q_d        = mag(dividend);
                  d_d        = mag(divisor);
                  neg_quot_d = dividend[W-1] ^ divisor[W-1];
                  neg_rem_d  = dividend[W-1];
`else
                  q_d        = dividend;
                  d_d        = divisor;
`endif
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ITERATE: begin
            busy_d = 1'b1;
            if (!trial_s[W]) begin
               a_d = trial_s[W-1:0];
               q_d = {q_q[W-2:0], 1'b1};
            end else begin
               a_d = a_shift_s[W-1:0];
               q_d = {q_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_FIXUP;
            end else begin
               state_d = S_ITERATE;
            end
         end
         S_FIXUP: begin
            ready_d    = 1'b1;
            dbz_pend_d = 1'b0;
            state_d    = S_DONE;
            if (dbz_pend_q) begin
               result_d    = ONES_W;
               remainder_d = q_q;
               dbz_d       = 1'b1;
            end else begin
`ifdef DIVIDER_SIGNED_EN
               result_d    = neg_if(q_q, neg_quot_q);
               remainder_d = neg_if(a_q, neg_rem_q);
`else
               result_d    = q_q;
               remainder_d = a_q;
`endif
               dbz_d       = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; reset clears everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         a_q         <= ZERO_W;
         q_q         <= ZERO_W;
         d_q         <= ZERO_W;
         cnt_q       <= {CW{1'b0}};
         dbz_pend_q  <= 1'b0;
         result_q    <= ZERO_W;
         remainder_q <= ZERO_W;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_quot_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         q_q         <= q_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         dbz_pend_q  <= dbz_pend_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
`ifdef DIVIDER_SIGNED_EN
         neg_quot_q  <= neg_quot_d;
         neg_rem_q   <= neg_rem_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign ready       = ready_q;
   assign result      = result_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed self-checking bench for divider_sequencer (WORD_LENGTH=16).
// Signed vectors are exercised when DIVIDER_SIGNED_EN is defined.
module tb_divider_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        ready;
   logic [15:0] result;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks;
   int errors;
   int lat;
   int bcnt;
   int extra_ready;

   divider_sequencer #(.WORD_LENGTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .ready       (ready),
      .result      (result),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request for one clock; returns at the negedge after the accepting edge.
   task automatic launch(input logic [15:0] a, input logic [15:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Wait (bounded) for ready; lat=1 is the negedge right after the accepting edge.
   task automatic wait_ready(output int l, output int bc);
      l  = 1;
      bc = 0;
      while (ready !== 1'b1 && l < 40) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         l++;
      end
      check_eq("ready_seen", {31'd0, ready}, 32'd1);
   endtask

   task automatic expect_result(input string tag, input logic [15:0] q, input logic [15:0] r, input logic z);
      check_eq({tag, "_result"}, {16'd0, result}, {16'd0, q});
      check_eq({tag, "_remainder"}, {16'd0, remainder}, {16'd0, r});
      check_eq({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, z});
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      start    = 1'b0;
      dividend = 16'd0;
      divisor  = 16'd0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_ready", {31'd0, ready}, 32'd0);
      expect_result("rst", 16'd0, 16'd0, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // 100/7: 17 busy cycles, ready 18 cycles after start
      launch(16'd100, 16'd7);
      wait_ready(lat, bcnt);
      check_eq("lat_100_7", lat, 32'd18);
      check_eq("busy_100_7", bcnt, 32'd17);
      expect_result("d100_7", 16'd14, 16'd2, 1'b0);
      @(negedge clk);
      check_eq("ready_pulse", {31'd0, ready}, 32'd0);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);

      // 0xFFFF/1 then back-to-back 9/4 issued in the DONE cycle
      launch(16'hFFFF, 16'h0001);
      wait_ready(lat, bcnt);
      expect_result("dffff_1", 16'hFFFF, 16'h0000, 1'b0);
      launch(16'h0009, 16'h0004);
      check_eq("b2b_busy", {31'd0, busy}, 32'd1);
      check_eq("b2b_ready_low", {31'd0, ready}, 32'd0);
      wait_ready(lat, bcnt);
      check_eq("lat_b2b", lat, 32'd18);
      expect_result("d9_4", 16'd2, 16'd1, 1'b0);
      @(negedge clk);

      // 1234/0: ready two cycles after start, busy never high
      launch(16'd1234, 16'd0);
      wait_ready(lat, bcnt);
      check_eq("lat_dbz", lat, 32'd2);
      check_eq("busy_dbz", bcnt, 32'd0);
      check_eq("busy_dbz_done", {31'd0, busy}, 32'd0);
      expect_result("d1234_0", 16'hFFFF, 16'd1234, 1'b1);
      @(negedge clk);
      launch(16'd10, 16'd3);
      wait_ready(lat, bcnt);
      expect_result("d10_3", 16'd3, 16'd1, 1'b0);
      @(negedge clk);

      // 500/3 aborted by an asynchronous reset in the 5th ITERATE cycle
      launch(16'd500, 16'd3);
      repeat (4) @(negedge clk);
      check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_ready", {31'd0, ready}, 32'd0);
      expect_result("abort", 16'd0, 16'd0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_idle", {31'd0, busy}, 32'd0);
      launch(16'd9, 16'd4);
      wait_ready(lat, bcnt);
      check_eq("lat_after_abort", lat, 32'd18);
      expect_result("post_abort", 16'd2, 16'd1, 1'b0);
      @(negedge clk);

      // 50/5 with a second start (7/7) pulsed during the 3rd ITERATE cycle
      launch(16'd50, 16'd5);
      repeat (2) @(negedge clk);
      launch(16'd7, 16'd7);
      wait_ready(lat, bcnt);
      expect_result("d50_5", 16'd10, 16'd0, 1'b0);
      extra_ready = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ready === 1'b1) extra_ready++;
      end
      check_eq("dropped_start", extra_ready, 32'd0);
      check_eq("dropped_busy", {31'd0, busy}, 32'd0);

`ifdef DIVIDER_SIGNED_EN
      launch(16'hFFF9, 16'h0002);
      wait_ready(lat, bcnt);
      check_eq("lat_signed", lat, 32'd18);
      expect_result("s_m7_2", 16'hFFFD, 16'hFFFF, 1'b0);
      @(negedge clk);
      launch(16'h0007, 16'hFFFE);
      wait_ready(lat, bcnt);
      expect_result("s_7_m2", 16'hFFFD, 16'h0001, 1'b0);
      @(negedge clk);
      launch(16'h8000, 16'hFFFF);
      wait_ready(lat, bcnt);
      expect_result("s_min_m1", 16'h8000, 16'h0000, 1'b0);
      @(negedge clk);
`else
      launch(16'hFFF9, 16'h0002);
      wait_ready(lat, bcnt);
      expect_result("u_fff9_2", 16'h7FFC, 16'h0001, 1'b0);
      @(negedge clk);
      launch(16'h8000, 16'hFFFF);
      wait_ready(lat, bcnt);
      expect_result("u_8000_ffff", 16'h0000, 16'h8000, 1'b0);
      @(negedge clk);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
